alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_op_sequencer_if.sv | 33 +++
 rtl/cmd_fifo.sv | 58 +++++
 rtl/alu_op_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: field widths, FSM encoding and the
// packed command record carried through the command FIFO.
package alu_seq_pkg;

    localparam int OP_W   = 8;
    localparam int REG_W  = 4;
    localparam int IMM_W  = 16;
    localparam int FLAG_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_READ,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] srca;
        logic [REG_W-1:0] srcb;
        logic             use_imm;
        logic             cin;
        logic [IMM_W-1:0] imm;
        logic             rdbk;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Register-file port select word: enable bit on top of the index.
    function automatic logic [REG_W:0] reg_sel(input logic [REG_W-1:0] idx);
        return {1'b1, idx};
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake channels between a host and the sequencer.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [REG_W-1:0]  cmd_dst;
    logic [REG_W-1:0]  cmd_srca;
    logic [REG_W-1:0]  cmd_srcb;
    logic              cmd_use_imm;
    logic              cmd_cin;
    logic [IMM_W-1:0]  cmd_imm;
    logic              cmd_rdbk;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [FLAG_W-1:0] rsp_flags;
    logic [IMM_W-1:0]  rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb,
               cmd_use_imm, cmd_cin, cmd_imm, cmd_rdbk, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_flags, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb,
               cmd_use_imm, cmd_cin, cmd_imm, cmd_rdbk, rsp_ready,
        output cmd_ready, rsp_valid, rsp_flags, rsp_data
    );

endinterface

// File: rtl/cmd_fifo.sv
// Small first-word-fall-through FIFO with an occupancy count; the head entry
// is always visible on dout so the consumer can load it on the pop edge.
module cmd_fifo #(
    parameter int  WIDTH = 39,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count_reg != CW'(DEPTH));
    assign pop_ok  = pop && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU commands and steps each through issue, flag capture, optional
// destination read-back and a held response to the host.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    alu_op_sequencer_if.slave  bus,
    output logic [OP_W-1:0]    alu_op,
    output logic [REG_W:0]     reg_en,
    output logic [REG_W:0]     buf_en_a,
    output logic [REG_W:0]     buf_en_b,
    output logic [IMM_W-1:0]   imm,
    output logic               imm_en,
    output logic               cin,
    input  logic [FLAG_W-1:0]  flags,
    output logic [5:0]         reg_read_number,
    input  logic [IMM_W-1:0]   reg_read_data,
    output logic               busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state_reg, state_next;
    cmd_t              cmd_reg;
    cmd_t              in_cmd;
    logic [CMD_W-1:0]  head_bits;
    logic [CNT_W-1:0]  fifo_count;
    logic              push;
    logic              pop;
    logic [FLAG_W-1:0] rsp_flags_reg;
    logic [IMM_W-1:0]  rsp_data_reg;

    assign in_cmd = '{op: bus.cmd_op, dst: bus.cmd_dst, srca: bus.cmd_srca,
                      srcb: bus.cmd_srcb, use_imm: bus.cmd_use_imm,
                      cin: bus.cmd_cin, imm: bus.cmd_imm, rdbk: bus.cmd_rdbk};

    // Ready depends only on occupancy, never on a pop in the same cycle.
    assign bus.cmd_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_cmd),
        .dout  (head_bits),
        .count (fifo_count)
    );

    always_comb begin
        state_next      = state_reg;
        pop             = 1'b0;
        alu_op          = '0;
        reg_en          = '0;
        buf_en_a        = '0;
        buf_en_b        = '0;
        imm             = '0;
        imm_en          = 1'b0;
        cin             = 1'b0;
        reg_read_number = '0;
        case (state_reg)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_op     = cmd_reg.op;
                reg_en     = reg_sel(cmd_reg.dst);
                buf_en_a   = reg_sel(cmd_reg.srca);
                buf_en_b   = cmd_reg.use_imm ? '0 : reg_sel(cmd_reg.srcb);
                imm        = cmd_reg.imm;
                imm_en     = cmd_reg.use_imm;
                cin        = cmd_reg.cin;
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_next = cmd_reg.rdbk ? S_READ : S_RESP;
            end
            S_READ: begin
                reg_read_number = {2'b00, cmd_reg.dst};
                state_next      = S_RESP;
            end
            S_RESP: begin
                // Back-to-back commands skip IDLE to save a cycle.
                if (bus.rsp_ready) begin
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cmd_reg       <= '0;
            rsp_flags_reg <= '0;
            rsp_data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                cmd_reg <= cmd_t'(head_bits);
            end
            if (state_reg == S_CAPTURE) begin
                rsp_flags_reg <= flags;
                rsp_data_reg  <= '0;
            end
            if (state_reg == S_READ) begin
                rsp_data_reg <= reg_read_data;
            end
        end
    end

    assign bus.rsp_valid = (state_reg == S_RESP);
    assign bus.rsp_flags = rsp_flags_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign busy          = (fifo_count != '0) || (state_reg != S_IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a response scoreboard and a simple
// datapath model (flags derived from the issued op/dst, fixed register file).
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    typedef struct packed {
        logic [4:0]  flags;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  alu_op;
    logic [4:0]  reg_en, buf_en_a, buf_en_b;
    logic [15:0] imm;
    logic        imm_en, cin;
    logic [4:0]  flags;
    logic [5:0]  reg_read_number;
    logic [15:0] reg_read_data;
    logic        busy;
    logic [4:0]  flags_q = 5'b0;

    int   total = 0;
    int   bad = 0;
    int   strobe_cnt = 0;
    int   rsp_cnt = 0;
    exp_t exp_q[$];

    alu_op_sequencer_if bus();

    alu_op_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus),
        .alu_op          (alu_op),
        .reg_en          (reg_en),
        .buf_en_a        (buf_en_a),
        .buf_en_b        (buf_en_b),
        .imm             (imm),
        .imm_en          (imm_en),
        .cin             (cin),
        .flags           (flags),
        .reg_read_number (reg_read_number),
        .reg_read_data   (reg_read_data),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] reg_val(input logic [3:0] i);
        return (i == 4'd3) ? 16'h1234 : {i, ~i, i ^ 4'h5, 4'hA};
    endfunction

    always @(posedge clk) begin
        if (reg_en[4]) flags_q <= alu_op[4:0] ^ {1'b0, reg_en[3:0]};
    end
    assign flags         = flags_q;
    assign reg_read_data = reg_val(reg_read_number[3:0]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [3:0] dst, input logic [3:0] srca,
                            input logic [3:0] srcb, input logic use_imm, input logic c_in,
                            input logic [15:0] imm_v, input logic rdbk, output logic accepted);
        exp_t e;
        bus.cmd_valid   = 1'b1;
        bus.cmd_op      = op;
        bus.cmd_dst     = dst;
        bus.cmd_srca    = srca;
        bus.cmd_srcb    = srcb;
        bus.cmd_use_imm = use_imm;
        bus.cmd_cin     = c_in;
        bus.cmd_imm     = imm_v;
        bus.cmd_rdbk    = rdbk;
        accepted        = bus.cmd_ready;
        if (accepted) begin
            e.flags = op[4:0] ^ {1'b0, dst};
            e.data  = rdbk ? reg_val(dst) : 16'h0000;
            exp_q.push_back(e);
            $display("push op=%02h dst=%0d rdbk=%0b exp_flags=%05b exp_data=%04h",
                     op, dst, rdbk, e.flags, e.data);
        end else begin
            $display("push op=%02h dst=%0d refused", op, dst);
        end
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < budget && (busy || exp_q.size() != 0); i++) step();
        chk("drain_busy", {31'b0, busy}, 0);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    // Scoreboard: compare every completed response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (reg_en[4]) strobe_cnt++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    $display("rsp flags=%05b data=%04h exp_flags=%05b exp_data=%04h",
                             bus.rsp_flags, bus.rsp_data, e.flags, e.data);
                    chk("rsp_flags", bus.rsp_flags, e.flags);
                    chk("rsp_data", bus.rsp_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   s0, r0;
        logic [3:0] kk;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0; bus.cmd_srca = '0;
        bus.cmd_srcb = '0; bus.cmd_use_imm = 1'b0; bus.cmd_cin = 1'b0; bus.cmd_imm = '0;
        bus.cmd_rdbk = 1'b0; bus.rsp_ready = 1'b0;

        // Reset values
        step(); step();
        chk("rst_cmd_ready", {31'b0, bus.cmd_ready}, 1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
        chk("rst_rsp_flags", bus.rsp_flags, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_ctrl", {alu_op, reg_en, buf_en_a, buf_en_b, imm_en, cin}, 0);
        chk("rst_imm", imm, 0);
        chk("rst_rdnum", reg_read_number, 0);
        reset = 1'b0;
        step();

        // Register-source command with read-back
        s0 = strobe_cnt;
        push_cmd(8'h01, 4'd3, 4'd1, 4'd2, 1'b0, 1'b0, 16'h0, 1'b1, acc);
        chk("t1_accept", {31'b0, acc}, 1);
        step();
        chk("t1_reg_en", reg_en, 5'h13);
        chk("t1_buf_a", buf_en_a, 5'h11);
        chk("t1_buf_b", buf_en_b, 5'h12);
        chk("t1_alu_op", alu_op, 8'h01);
        chk("t1_imm_en", {31'b0, imm_en}, 0);
        step();
        chk("t1_reg_en_off", reg_en, 0);
        chk("t1_valid_n2", {31'b0, bus.rsp_valid}, 0);
        step();
        chk("t1_rdnum", reg_read_number, 6'h03);
        chk("t1_valid_n3", {31'b0, bus.rsp_valid}, 0);
        step();
        chk("t1_valid_n4", {31'b0, bus.rsp_valid}, 1);
        chk("t1_flags", bus.rsp_flags, 5'b00010);
        chk("t1_data", bus.rsp_data, 16'h1234);
        chk("t1_rdnum_off", reg_read_number, 0);
        chk("t1_strobes", strobe_cnt - s0, 1);
        wait_idle(20);

        // Immediate operand, no read-back
        bus.rsp_ready = 1'b0;
        push_cmd(8'h22, 4'd5, 4'd7, 4'd9, 1'b1, 1'b1, 16'hBEEF, 1'b0, acc);
        step();
        chk("t2_imm_en", {31'b0, imm_en}, 1);
        chk("t2_imm", imm, 16'hBEEF);
        chk("t2_buf_b", buf_en_b, 0);
        chk("t2_buf_a", buf_en_a, 5'h17);
        chk("t2_cin", {31'b0, cin}, 1);
        chk("t2_reg_en", reg_en, 5'h15);
        step();
        chk("t2_imm_en_off", {31'b0, imm_en}, 0);
        chk("t2_imm_off", imm, 0);
        step();
        chk("t2_valid_n3", {31'b0, bus.rsp_valid}, 1);
        chk("t2_data", bus.rsp_data, 0);
        chk("t2_flags", bus.rsp_flags, 5'b00111);
        wait_idle(20);

        // Fill behind a stalled response, then push while full with a pop
        bus.rsp_ready = 1'b0;
        r0 = rsp_cnt;
        for (int k = 0; k < 5; k++) begin
            kk = 4'(k);
            push_cmd(8'h10 + 8'(k), kk + 4'd1, kk, kk + 4'd2, kk[0], ~kk[0],
                     16'h1000 + 16'(k), kk[1], acc);
            chk("t3_accept", {31'b0, acc}, 1);
        end
        chk("t3_ready_full", {31'b0, bus.cmd_ready}, 0);
        chk("t3_count_full", 32'(dut.fifo_count), 4);
        chk("t3_busy", {31'b0, busy}, 1);
        bus.rsp_ready = 1'b1;
        push_cmd(8'h77, 4'd8, 4'd8, 4'd8, 1'b0, 1'b0, 16'h7777, 1'b0, acc);
        chk("t4_refused", {31'b0, acc}, 0);
        chk("t4_count_after_pop", 32'(dut.fifo_count), 3);
        chk("t4_ready_after_pop", {31'b0, bus.cmd_ready}, 1);
        wait_idle(100);
        chk("t3_rsp_count", rsp_cnt - r0, 5);

        // Reset while issuing with two commands still queued
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            kk = 4'(k);
            push_cmd(8'h40 + 8'(k), kk + 4'd4, kk, kk, 1'b0, 1'b0, 16'h0, 1'b0, acc);
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("t5_in_issue", {31'b0, reg_en[4]}, 1);
        chk("t5_count_q", 32'(dut.fifo_count), 2);
        #1 reset = 1'b1;
        #1;
        chk("t5_async_ctrl", {alu_op, reg_en, buf_en_a, buf_en_b, imm_en, cin}, 0);
        chk("t5_async_valid", {31'b0, bus.rsp_valid}, 0);
        chk("t5_async_busy", {31'b0, busy}, 0);
        chk("t5_async_ready", {31'b0, bus.cmd_ready}, 1);
        exp_q.delete();
        step(); step();
        reset = 1'b0;
        s0 = strobe_cnt;
        repeat (4) step();
        chk("t5_no_strobe", strobe_cnt - s0, 0);
        chk("t5_busy", {31'b0, busy}, 0);
        chk("t5_ready", {31'b0, bus.cmd_ready}, 1);
        chk("t5_rsp_flags", bus.rsp_flags, 0);

        // Command on the very first edge after reset release
        reset = 1'b1;
        step();
        reset = 1'b0;
        push_cmd(8'h05, 4'd6, 4'd2, 4'd4, 1'b0, 1'b1, 16'h0, 1'b1, acc);
        chk("t6_accept", {31'b0, acc}, 1);
        step();
        chk("t6_reg_en", reg_en, 5'h16);
        wait_idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
